axi_lite_mem_arbiter: RTL and testbench

Shares the core's single AXI-Lite master port between the instruction-fetch requester (IF) and the data-memory requester (MEM). It sequences one AXI-Lite transaction at a time and gives data priority over instruction fetch. It raises a stall request to the pipeline controller while any request is outstanding, and discards in-flight read results when the pipeline is flushed by an exception.

---
 rtl/axi_lite_mem_arbiter_if.sv | 46 ++++
 rtl/axi_lite_mem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_axi_lite_mem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_mem_arbiter_if.sv
// AXI-Lite bus bundle between the IF/MEM arbiter (master) and the memory system (slave).
// Carries the five AXI-Lite channels; widths follow the arbiter parameters.
interface axi_lite_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;

  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;

  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/axi_lite_mem_arbiter.sv
// Shares one AXI-Lite master port between instruction fetch and data memory, one
// transaction at a time, data first; flushed reads complete on the bus but report nothing.
module axi_lite_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_req,
  input  logic [ADDR_W-1:0]    inst_addr,
  output logic [DATA_W-1:0]    inst_rdata,
  output logic                 inst_done,
  input  logic                 data_req,
  input  logic                 data_we,
  input  logic [DATA_W/8-1:0]  data_wstrb,
  input  logic [ADDR_W-1:0]    data_addr,
  input  logic [DATA_W-1:0]    data_wdata,
  output logic [DATA_W-1:0]    data_rdata,
  output logic                 data_done,
  input  logic                 flush,
  output logic                 stall_req,
  output logic                 bus_err,
  axi_lite_mem_arbiter_if.master axi
);
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              id_data_q, id_data_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              aw_ok_q, aw_ok_d;
  logic              w_ok_q, w_ok_d;
  logic              discard_q, discard_d;
  logic              inst_done_q, inst_done_d;
  logic              data_done_q, data_done_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              rd_kill;

  // Next-state and output decode; done/err/rdata are loaded on entry to DONE
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    id_data_d    = id_data_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    aw_ok_d      = aw_ok_q;
    w_ok_d       = w_ok_q;
    discard_d    = discard_q;
    inst_done_d  = 1'b0;
    data_done_d  = 1'b0;
    bus_err_d    = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    // A flush in the completing cycle must also suppress the result
    rd_kill      = discard_q | flush;

    unique case (state_q)
      IDLE: begin
        if (!flush && (data_req || inst_req)) begin
          id_data_d = data_req;
          addr_d    = data_req ? data_addr : inst_addr;
          if (data_req) begin
            wdata_d = data_wdata;
            wstrb_d = data_wstrb;
          end
          if (data_req && data_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_ok_d   = 1'b0;
            w_ok_d    = 1'b0;
            state_d   = WR_ADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        discard_d = rd_kill;
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        discard_d = rd_kill;
        if (axi.rvalid) begin
          rready_d = 1'b0;
          state_d  = DONE;
          if (!rd_kill) begin
            bus_err_d = |axi.rresp;
            if (id_data_q) begin
              data_done_d  = 1'b1;
              data_rdata_d = axi.rdata;
            end else begin
              inst_done_d  = 1'b1;
              inst_rdata_d = axi.rdata;
            end
          end
        end
      end
      WR_ADDR: begin
        // AW and W complete independently, possibly in the same cycle
        awvalid_d = awvalid_q & ~axi.awready;
        wvalid_d  = wvalid_q & ~axi.wready;
        aw_ok_d   = aw_ok_q | (awvalid_q & axi.awready);
        w_ok_d    = w_ok_q | (wvalid_q & axi.wready);
        if (aw_ok_d && w_ok_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (axi.bvalid) begin
          bready_d    = 1'b0;
          data_done_d = 1'b1;
          bus_err_d   = |axi.bresp;
          state_d     = DONE;
        end
      end
      DONE: begin
        discard_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      id_data_q    <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_ok_q      <= 1'b0;
      w_ok_q       <= 1'b0;
      discard_q    <= 1'b0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      bus_err_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      id_data_q    <= id_data_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      aw_ok_q      <= aw_ok_d;
      w_ok_q       <= w_ok_d;
      discard_q    <= discard_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      bus_err_q    <= bus_err_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign axi.araddr  = addr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign axi.awaddr  = addr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  assign inst_done  = inst_done_q;
  assign data_done  = data_done_q;
  assign bus_err    = bus_err_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  assign stall_req = (inst_req & ~inst_done_q) | (data_req & ~data_done_q);
endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Scoreboard bench for axi_lite_mem_arbiter: directed requests, a programmable-wait
// AXI-Lite slave, and a monitor that checks every done pulse against queued expectations.
module tb_axi_lite_mem_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef struct packed {
    logic        is_data;
    logic        is_read;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_done;
  logic              data_req;
  logic              data_we;
  logic [STRB_W-1:0] data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_done;
  logic              flush;
  logic              stall_req;
  logic              bus_err;

  axi_lite_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  axi_lite_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_done  (inst_done),
    .data_req   (data_req),
    .data_we    (data_we),
    .data_wstrb (data_wstrb),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .data_done  (data_done),
    .flush      (flush),
    .stall_req  (stall_req),
    .bus_err    (bus_err),
    .axi        (axi)
  );

  int checks = 0;
  int errors = 0;

  exp_t        exp_q[$];
  logic [31:0] ar_q[$];
  logic [33:0] r_rsp_q[$];
  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];
  logic [1:0]  b_q[$];

  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Slave: samples handshakes at negedge, drives its outputs 1 time unit after posedge
  initial begin : slave
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic r_pend, b_pend, aw_got, w_got;
    int   ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic [31:0] cur_rdata;
    logic [1:0]  cur_rresp, cur_bresp;
    logic [33:0] rsp;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    cur_rdata = '0; cur_rresp = '0; cur_bresp = '0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = '0;
    forever begin
      @(negedge clk);
      ar_hs = !rst && axi.arvalid && axi.arready;
      r_hs  = !rst && axi.rvalid && axi.rready;
      aw_hs = !rst && axi.awvalid && axi.awready;
      w_hs  = !rst && axi.wvalid && axi.wready;
      b_hs  = !rst && axi.bvalid && axi.bready;
      if (ar_hs) begin
        chk("ar_expected", ar_q.size() != 0, 1);
        if (ar_q.size() != 0) chk("araddr", axi.araddr, ar_q.pop_front());
        rsp = (r_rsp_q.size() != 0) ? r_rsp_q.pop_front() : 34'h0;
        cur_rresp = rsp[33:32];
        cur_rdata = rsp[31:0];
      end
      if (aw_hs) begin
        chk("aw_expected", aw_q.size() != 0, 1);
        if (aw_q.size() != 0) chk("awaddr", axi.awaddr, aw_q.pop_front());
      end
      if (w_hs) begin
        chk("w_expected", w_q.size() != 0, 1);
        if (w_q.size() != 0) chk("wstrb_wdata", {axi.wstrb, axi.wdata}, w_q.pop_front());
      end
      @(posedge clk);
      #1;
      if (rst) begin
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        axi.arready = 0; axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
      end else begin
        if (ar_hs) begin r_pend = 1; r_cnt = 0; end
        if (r_hs) r_pend = 0;
        axi.rvalid = r_pend && (r_cnt == r_wait);
        axi.rdata  = cur_rdata;
        axi.rresp  = cur_rresp;
        if (r_pend && !axi.rvalid) r_cnt++;

        if (!axi.arvalid) ar_cnt = 0;
        axi.arready = axi.arvalid && (ar_cnt == ar_wait);
        if (axi.arvalid && !axi.arready) ar_cnt++;

        if (aw_hs) aw_got = 1;
        if (w_hs) w_got = 1;
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
          cur_bresp = (b_q.size() != 0) ? b_q.pop_front() : 2'b00;
        end
        if (b_hs) b_pend = 0;
        axi.bvalid = b_pend && (b_cnt == b_wait);
        axi.bresp  = cur_bresp;
        if (b_pend && !axi.bvalid) b_cnt++;

        if (!axi.awvalid) aw_cnt = 0;
        axi.awready = axi.awvalid && (aw_cnt == aw_wait);
        if (axi.awvalid && !axi.awready) aw_cnt++;

        if (!axi.wvalid) w_cnt = 0;
        axi.wready = axi.wvalid && (w_cnt == w_wait);
        if (axi.wvalid && !axi.wready) w_cnt++;
      end
    end
  end

  // Monitor: every done pulse is matched against the oldest expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (inst_done || data_done) begin
          chk("done_onehot", inst_done & data_done, 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_done", {inst_done, data_done}, 2'b00);
          end else begin
            e = exp_q.pop_front();
            chk("done_id", data_done, e.is_data);
            if (e.is_read) chk("rdata", data_done ? data_rdata : inst_rdata, e.rdata);
            chk("bus_err", bus_err, e.err);
          end
        end else begin
          chk("stray_bus_err", bus_err, 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (inst_done) inst_req = 0;
    if (data_done) data_req = 0;
    #1;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    while ((inst_req || data_req) && n < max_cyc) begin
      tick();
      n++;
    end
    chk({name, "_complete"}, inst_req | data_req, 0);
  endtask

  task automatic push_read(input logic is_data, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [1:0] resp, input logic expect_done);
    ar_q.push_back(addr);
    r_rsp_q.push_back({resp, rd});
    if (expect_done) exp_q.push_back('{is_data: is_data, is_read: 1'b1, rdata: rd, err: resp != 2'b00});
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] strb, input logic [1:0] resp);
    aw_q.push_back(addr);
    w_q.push_back({strb, wd});
    b_q.push_back(resp);
    exp_q.push_back('{is_data: 1'b1, is_read: 1'b0, rdata: 32'h0, err: resp != 2'b00});
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int dcyc, icyc, dcnt, icnt;
    rst = 1; inst_req = 0; inst_addr = '0; data_req = 0; data_we = 0;
    data_wstrb = '0; data_addr = '0; data_wdata = '0; flush = 0;
    tick(); tick();
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_awvalid_wvalid", {axi.awvalid, axi.wvalid}, 2'b00);
    chk("rst_rready_bready", {axi.rready, axi.bready}, 2'b00);
    chk("rst_dones_err", {inst_done, data_done, bus_err}, 3'b000);
    chk("rst_rdata", {inst_rdata, data_rdata}, 64'h0);
    chk("rst_araddr", axi.araddr, 0);
    chk("rst_stall", stall_req, 0);
    rst = 0;
    tick();

    // Zero-wait instruction fetch
    push_read(1'b0, 32'hBFC0_0000, 32'h3C1D_8000, 2'b00, 1'b1);
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    #1 chk("rd_c0_stall", stall_req, 1);
    chk("rd_c0_arvalid", axi.arvalid, 0);
    tick();
    chk("rd_c1_arvalid", axi.arvalid, 1);
    chk("rd_c1_araddr", axi.araddr, 32'hBFC0_0000);
    chk("rd_c1_stall", stall_req, 1);
    tick();
    chk("rd_c2_rready_arvalid", {axi.rready, axi.arvalid}, 2'b10);
    chk("rd_c2_stall", stall_req, 1);
    tick();
    chk("rd_c3_inst_done", inst_done, 1);
    chk("rd_c3_inst_rdata", inst_rdata, 32'h3C1D_8000);
    chk("rd_c3_stall", stall_req, 0);
    tick();
    chk("rd_c4_inst_done", inst_done, 0);

    // Simultaneous requests: data read wins, fetch follows
    push_read(1'b1, 32'h8000_1000, 32'h1111_2222, 2'b00, 1'b1);
    push_read(1'b0, 32'hBFC0_0004, 32'h3333_4444, 2'b00, 1'b1);
    data_req = 1; data_we = 0; data_addr = 32'h8000_1000;
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    dcyc = -1; icyc = -1; dcnt = 0; icnt = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) chk("pri_c1_araddr", axi.araddr, 32'h8000_1000);
      if (data_done) begin dcyc = c; dcnt++; end
      if (inst_done) begin icyc = c; icnt++; end
    end
    chk("pri_data_done_cycle", dcyc, 3);
    chk("pri_inst_done_cycle", icyc, 7);
    chk("pri_done_counts", {dcnt[3:0], icnt[3:0]}, 8'h11);

    // Write with W delayed two cycles behind AW
    w_wait = 2;
    push_write(32'h8000_2000, 32'h1234_ABCD, 4'b0011, 2'b00);
    data_req = 1; data_we = 1; data_addr = 32'h8000_2000;
    data_wdata = 32'h1234_ABCD; data_wstrb = 4'b0011;
    tick();
    chk("wr_c1_aw_w_valid", {axi.awvalid, axi.wvalid}, 2'b11);
    chk("wr_c1_awaddr", axi.awaddr, 32'h8000_2000);
    tick();
    chk("wr_c2_aw_w_valid", {axi.awvalid, axi.wvalid}, 2'b01);
    tick();
    chk("wr_c3_wvalid_bready", {axi.wvalid, axi.bready}, 2'b10);
    chk("wr_c3_wstrb_wdata", {axi.wstrb, axi.wdata}, {4'b0011, 32'h1234_ABCD});
    tick();
    chk("wr_c4_wvalid_bready", {axi.wvalid, axi.bready}, 2'b01);
    tick();
    chk("wr_c5_data_done", data_done, 1);
    chk("wr_c5_bready", axi.bready, 0);
    w_wait = 0;
    tick();

    // Flushed fetch with error response: nothing reported, rdata held
    push_read(1'b0, 32'hBFC0_0010, 32'hDEAD_BEEF, 2'b10, 1'b0);
    inst_req = 1; inst_addr = 32'hBFC0_0010;
    tick();
    chk("fl_c1_arvalid", axi.arvalid, 1);
    tick();
    flush = 1; inst_req = 0;
    tick();
    flush = 0;
    chk("fl_c3_no_done", {inst_done, data_done, bus_err}, 3'b000);
    chk("fl_c3_inst_rdata_held", inst_rdata, 32'h3333_4444);
    push_read(1'b0, 32'hBFC0_0020, 32'h0BAD_F00D, 2'b00, 1'b1);
    inst_req = 1; inst_addr = 32'hBFC0_0020;
    tick();
    chk("fl_c4_arvalid", axi.arvalid, 0);
    tick();
    chk("fl_c5_arvalid", axi.arvalid, 1);
    chk("fl_c5_araddr", axi.araddr, 32'hBFC0_0020);
    wait_idle("fl_refetch", 20);
    tick();

    // Flush in IDLE blocks the grant; flush during the write does not cancel it
    push_write(32'h8000_3000, 32'hCAFE_F00D, 4'b1111, 2'b01);
    data_req = 1; data_we = 1; data_addr = 32'h8000_3000;
    data_wdata = 32'hCAFE_F00D; data_wstrb = 4'b1111; flush = 1;
    dcyc = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin
        chk("flw_c1_no_grant", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b000);
        flush = 0;
      end
      if (c == 2) begin
        chk("flw_c2_aw_w_valid", {axi.awvalid, axi.wvalid}, 2'b11);
        flush = 1;
      end
      if (c == 3) flush = 0;
      if (data_done && dcyc < 0) dcyc = c;
    end
    chk("flw_done_cycle", dcyc, 4);

    // Read with slave waits and an error response
    ar_wait = 1; r_wait = 2;
    push_read(1'b1, 32'h8000_4000, 32'h55AA_55AA, 2'b10, 1'b1);
    data_req = 1; data_we = 0; data_addr = 32'h8000_4000;
    dcyc = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 2) chk("err_c2_arvalid_held", {axi.arvalid, axi.araddr}, {1'b1, 32'h8000_4000});
      if (data_done && dcyc < 0) dcyc = c;
    end
    chk("err_done_cycle", dcyc, 6);
    ar_wait = 0; r_wait = 0;

    // Reset in the middle of a read
    r_wait = 5;
    push_read(1'b0, 32'hBFC0_0030, 32'h7777_8888, 2'b00, 1'b1);
    inst_req = 1; inst_addr = 32'hBFC0_0030;
    tick();
    tick();
    chk("rs_c2_rready", axi.rready, 1);
    rst = 1;
    #1;
    chk("rs_valids_drop", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 5'b0);
    chk("rs_no_done", {inst_done, data_done}, 2'b00);
    exp_q.delete();
    inst_req = 0;
    r_wait = 0;
    tick();
    tick();
    rst = 0;
    chk("rs_inst_rdata_cleared", inst_rdata, 0);
    tick();
    push_read(1'b0, 32'hBFC0_0040, 32'h0102_0304, 2'b00, 1'b1);
    inst_req = 1; inst_addr = 32'hBFC0_0040;
    tick(); tick(); tick();
    chk("rs_after_done_c3", inst_done, 1);
    chk("rs_after_rdata", inst_rdata, 32'h0102_0304);
    tick(); tick();

    chk("end_exp_q_empty", exp_q.size(), 0);
    chk("end_bus_q_empty", ar_q.size() + r_rsp_q.size() + aw_q.size() + w_q.size() + b_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
